// File: rtl/pc_branch_unit_pkg.sv
// Shared constants for the RV32I branch/PC unit: funct3 codes, state encoding, XLEN.
package rv32_br_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Decode/comparator/trap-side signals of the branch unit; stats outputs exist only under BRANCH_STATS_EN.
interface pc_branch_unit_if
  import rv32_br_pkg::*;
  ();

  logic            i_stall;
  logic            i_br_en;
  logic            i_jal;
  logic            i_jalr;
  logic [2:0]      i_funct3;
  logic            i_lt;
  logic            i_zero;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] i_rs1;
  logic            i_trap_ack;
  logic            o_br_unsigned;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_pc_plus4;
  logic            o_taken;
  logic            o_trap;
  logic [XLEN-1:0] o_mepc;
`ifdef BRANCH_STATS_EN
  logic [31:0]     o_br_cnt;
  logic [31:0]     o_br_taken_cnt;
`endif

  modport master (
    output i_stall, i_br_en, i_jal, i_jalr, i_funct3, i_lt, i_zero, i_imm, i_rs1, i_trap_ack,
`ifdef BRANCH_STATS_EN
    input  o_br_cnt, o_br_taken_cnt,
`endif
    input  o_br_unsigned, o_pc, o_pc_plus4, o_taken, o_trap, o_mepc
  );

  modport slave (
    input  i_stall, i_br_en, i_jal, i_jalr, i_funct3, i_lt, i_zero, i_imm, i_rs1, i_trap_ack,
`ifdef BRANCH_STATS_EN
    output o_br_cnt, o_br_taken_cnt,
`endif
    output o_br_unsigned, o_pc, o_pc_plus4, o_taken, o_trap, o_mepc
  );

endinterface

// File: rtl/pc_branch_unit_br_cond.sv
// Branch condition decode: funct3 plus comparator flags -> condition true.
module br_cond
  import rv32_br_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       lt,
  input  logic       zero,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = ~zero;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = lt;
      F3_BGEU: cond = ~lt;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// RV32I PC register, branch/jump resolution and misaligned-target trap handshake.
// Optional branch counters are compiled in with BRANCH_STATS_EN.
//
// state | meaning
// RUN   | PC advances / transfers; misaligned taken target raises a trap
// TRAP  | o_trap high, PC frozen until i_trap_ack loads TRAP_VEC
module pc_branch_unit
  import rv32_br_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pc_branch_unit_if.slave bus
);

  logic [0:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            cond;
  logic            taken;
  logic            misaligned;

  br_cond u_br_cond (
    .funct3 (bus.i_funct3),
    .lt     (bus.i_lt),
    .zero   (bus.i_zero),
    .cond   (cond)
  );

  assign jalr_sum   = bus.i_rs1 + bus.i_imm;
  assign target     = bus.i_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc + bus.i_imm;
  assign taken      = (state == ST_RUN) &&
                      (bus.i_jalr || bus.i_jal || (bus.i_br_en && cond));
  assign misaligned = taken && target[1];

  assign bus.o_br_unsigned = bus.i_funct3[1];
  assign bus.o_pc          = pc;
  assign bus.o_pc_plus4    = pc + 32'd4;
  assign bus.o_taken       = taken;
  assign bus.o_trap        = (state == ST_TRAP);
  assign bus.o_mepc        = mepc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
      mepc  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!bus.i_stall) begin
            if (misaligned) begin
              mepc  <= pc;
              state <= ST_TRAP;
            end else if (taken) begin
              pc <= target;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        default: begin
          if (bus.i_trap_ack) begin
            pc    <= TRAP_VEC;
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] br_taken_cnt;
  logic        br_slot;

  assign br_slot            = (state == ST_RUN) && !bus.i_stall && bus.i_br_en;
  assign bus.o_br_cnt       = br_cnt;
  assign bus.o_br_taken_cnt = br_taken_cnt;

  // Counters saturate rather than wrap so long runs stay monotonic.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else if (br_slot) begin
      if (br_cnt != '1) br_cnt <= br_cnt + 32'd1;
      if (taken && !misaligned && br_taken_cnt != '1) br_taken_cnt <= br_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit with a behavioural PC/trap model checked every cycle.
module tb_pc_branch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_branch_unit_if bus ();

  pc_branch_unit #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_pc, m_mepc, m_cnt, m_tcnt;
  bit          m_in_trap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Branch outcome from the ISA definition: compare flag, optionally inverted.
  function automatic bit isa_cond(input logic [2:0] f3, input bit lt, input bit zero);
    bit flag;
    if (f3 == 3'b010 || f3 == 3'b011) return 1'b0;
    flag = (f3 >= 3'b100) ? lt : zero;
    return (f3 % 2 == 1) ? !flag : flag;
  endfunction

  function automatic bit m_taken();
    if (m_in_trap) return 1'b0;
    return bus.i_jalr || bus.i_jal || (bus.i_br_en && isa_cond(bus.i_funct3, bus.i_lt, bus.i_zero));
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] t;
    if (bus.i_jalr) begin
      t = bus.i_rs1 + bus.i_imm;
      t = t - (t % 2);
    end else begin
      t = m_pc + bus.i_imm;
    end
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= RESET_PC; m_mepc <= 0; m_in_trap <= 0; m_cnt <= 0; m_tcnt <= 0;
    end else if (m_in_trap) begin
      if (bus.i_trap_ack) begin
        m_pc <= TRAP_VEC; m_in_trap <= 0;
      end
    end else if (!bus.i_stall) begin
      if (bus.i_br_en) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
        if (m_taken() && (m_target() % 4 == 0) && m_tcnt != 32'hFFFF_FFFF) m_tcnt <= m_tcnt + 1;
      end
      if (m_taken() && (m_target() % 4 != 0)) begin
        m_mepc <= m_pc; m_in_trap <= 1;
      end else if (m_taken()) begin
        m_pc <= m_target();
      end else begin
        m_pc <= m_pc + 4;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("pc", bus.o_pc, m_pc);
      check("pc_plus4", bus.o_pc_plus4, m_pc + 32'd4);
      check("taken", {31'd0, bus.o_taken}, {31'd0, m_taken()});
      check("trap", {31'd0, bus.o_trap}, {31'd0, m_in_trap});
      check("mepc", bus.o_mepc, m_mepc);
      check("br_unsigned", {31'd0, bus.o_br_unsigned}, {31'd0, bus.i_funct3 >= 3'b110 || bus.i_funct3 == 3'b010 || bus.i_funct3 == 3'b011});
`ifdef BRANCH_STATS_EN
      check("br_cnt", bus.o_br_cnt, m_cnt);
      check("br_taken_cnt", bus.o_br_taken_cnt, m_tcnt);
`endif
    end
  end

  task automatic drive(input bit stall, input bit br, input bit jal, input bit jalr,
                       input logic [2:0] f3, input bit lt, input bit zero,
                       input logic [31:0] imm, input logic [31:0] rs1, input bit ack);
    bus.i_stall = stall; bus.i_br_en = br; bus.i_jal = jal; bus.i_jalr = jalr;
    bus.i_funct3 = f3; bus.i_lt = lt; bus.i_zero = zero;
    bus.i_imm = imm; bus.i_rs1 = rs1; bus.i_trap_ack = ack;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    idle();
    #12;
    check("reset_pc", bus.o_pc, RESET_PC);
    check("reset_trap", {31'd0, bus.o_trap}, 32'd0);
    check("reset_mepc", bus.o_mepc, 32'd0);
    rst = 1'b0;
    tick(3);
    check("seq_pc_c", bus.o_pc, 32'h0000_000C);

    // trap_ack is ignored while running
    drive(0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0, 1);
    tick(1);
    check("ack_in_run", bus.o_pc, 32'h0000_0010);
    drive(0, 0, 1, 0, 3'b000, 0, 0, 32'h0000_00F0, 32'h0, 0);
    tick(1);
    check("jal_to_100", bus.o_pc, 32'h0000_0100);

    drive(0, 1, 0, 0, 3'b110, 1, 0, 32'h0000_0020, 32'h0, 0);
    #1;
    check("bltu_unsigned", {31'd0, bus.o_br_unsigned}, 32'd1);
    check("bltu_taken", {31'd0, bus.o_taken}, 32'd1);
    tick(1);
    check("bltu_pc", bus.o_pc, 32'h0000_0120);

    drive(0, 1, 0, 0, 3'b101, 1, 0, 32'h0000_0020, 32'h0, 0);
    #1;
    check("bge_not_taken", {31'd0, bus.o_taken}, 32'd0);
    tick(1);
    check("bge_pc", bus.o_pc, 32'h0000_0124);

    // funct3 010 never branches, even with both flags set
    drive(0, 1, 0, 0, 3'b010, 1, 1, 32'h0000_0040, 32'h0, 0);
    tick(1);
    check("f3_010_pc", bus.o_pc, 32'h0000_0128);

    drive(0, 0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FF18, 32'h0, 0);
    tick(1);
    check("jal_back_40", bus.o_pc, 32'h0000_0040);

    // misaligned target under stall must not trap
    drive(1, 0, 0, 1, 3'b000, 0, 0, 32'h0000_0001, 32'h0000_2001, 0);
    tick(1);
    check("stall_no_trap", {31'd0, bus.o_trap}, 32'd0);
    drive(0, 0, 0, 1, 3'b000, 0, 0, 32'h0000_0001, 32'h0000_2001, 0);
    tick(1);
    check("jalr_trap", {31'd0, bus.o_trap}, 32'd1);
    check("jalr_mepc", bus.o_mepc, 32'h0000_0040);
    for (int i = 0; i < 5; i++) begin
      drive(i % 2, 1, 1, 0, 3'b000, 0, 1, 32'h0000_0008, 32'h0, 0);
      tick(1);
    end
    check("trap_hold_pc", bus.o_pc, 32'h0000_0040);
    drive(0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0, 1);
    tick(1);
    check("ack_pc", bus.o_pc, TRAP_VEC);
    check("ack_trap_low", {31'd0, bus.o_trap}, 32'd0);

    drive(1, 1, 0, 0, 3'b000, 0, 1, 32'h0000_0008, 32'h0, 0);
    tick(2);
    check("beq_stall_pc", bus.o_pc, 32'h0000_0010);
    bus.i_stall = 1'b0;
    tick(1);
    check("beq_release_pc", bus.o_pc, 32'h0000_0018);

    drive(0, 0, 0, 1, 3'b000, 0, 0, 32'h0, 32'hFFFF_FFFC, 0);
    tick(1);
    check("top_pc", bus.o_pc, 32'hFFFF_FFFC);
    check("plus4_wrap", bus.o_pc_plus4, 32'h0000_0000);
    idle();
    tick(1);
    check("pc_wrap", bus.o_pc, 32'h0000_0000);

    // reset while trapped: async return to RUN at RESET_PC
    drive(0, 0, 0, 1, 3'b000, 0, 0, 32'h0000_0002, 32'h0000_0100, 0);
    tick(1);
    check("trap_again", {31'd0, bus.o_trap}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_trap", {31'd0, bus.o_trap}, 32'd0);
    check("async_rst_pc", bus.o_pc, RESET_PC);
    idle();
    #3 rst = 1'b0;
    @(posedge clk); #1;

`ifdef BRANCH_STATS_EN
    drive(0, 1, 0, 0, 3'b000, 0, 1, 32'h0000_0008, 32'h0, 0); tick(1);
    drive(0, 1, 0, 0, 3'b001, 0, 1, 32'h0000_0008, 32'h0, 0); tick(1);
    drive(0, 1, 0, 0, 3'b100, 1, 0, 32'h0000_0008, 32'h0, 0); tick(1);
    drive(0, 1, 0, 0, 3'b111, 0, 0, 32'h0000_0008, 32'h0, 0); tick(1);
    idle();
    tick(1);
    check("stats_br_cnt", bus.o_br_cnt, 32'd4);
    check("stats_taken_cnt", bus.o_br_taken_cnt, 32'd3);
`endif
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Consumes the lt/zero flags from the branch comparator and closes the loop.
- Drives the comparator's signed/unsigned mode, decides whether the branch is taken, and computes the next PC.
- Holds the architectural PC register of the RV32I core.
- Handles misaligned control-transfer targets with a two-state trap handshake toward the trap/CSR logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0010, PC value loaded when a trap is acknowledged.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_stall  in  1  hold PC this cycle (RUN only).
- i_br_en  in  1  current instruction is a conditional branch.
- i_jal  in  1  current instruction is JAL.
- i_jalr  in  1  current instruction is JALR.
- i_funct3  in  3  branch funct3 field.
- i_lt  in  1  comparator less-than result.
- i_zero  in  1  comparator equal (zero) result.
- i_imm  in  32  sign-extended immediate.
- i_rs1  in  32  rs1 operand for JALR.
- i_trap_ack  in  1  trap logic has consumed the trap.
- o_br_unsigned  out  1  comparator mode select: 1 = unsigned, 0 = signed.
- o_pc  out  32  current PC register.
- o_pc_plus4  out  32  o_pc + 4, used as the link value.
- o_taken  out  1  control transfer is taken this cycle.
- o_trap  out  1  misaligned-target trap pending.
- o_mepc  out  32  PC of the faulting instruction.

Behaviour:
- Reset (asynchronous): o_pc = RESET_PC, o_mepc = 0, state = RUN, o_trap = 0.
- o_br_unsigned = i_funct3[1], combinational, independent of state.
- Conditional-branch decode:
  - 000 BEQ: zero
  - 001 BNE: !zero
  - 100 BLT: lt
  - 101 BGE: !lt
  - 110 BLTU: lt
  - 111 BGEU: !lt
  - 010 / 011: never taken
- Source priority: i_jalr > i_jal > i_br_en.
- Target computation:
  - JALR: (i_rs1 + i_imm) & ~32'h1.
  - JAL or branch: o_pc + i_imm.
  - All adds are modulo 2^32; o_pc_plus4 wraps 0xFFFF_FFFC -> 0x0000_0000.
- o_taken: combinational; asserted in RUN when jal, jalr, or the branch condition is true; forced 0 in TRAP.
- Misaligned target: taken and target[1] = 1 (target[0] already cleared for JALR; for branch/JAL it is always 0 given a valid immediate).
- State RUN:
  - i_stall = 1: PC holds; no trap is raised even if the target is misaligned.
  - Taken and misaligned: o_mepc <= o_pc, PC holds, next state TRAP.
  - Taken and aligned: PC <= target.
  - Otherwise: PC <= o_pc + 4.
  - i_trap_ack is ignored.
- State TRAP:
  - o_trap = 1, PC holds, i_stall ignored.
  - i_trap_ack = 1: PC <= TRAP_VEC, next state RUN; o_trap is low from the following cycle.
- Latency: a one-cycle PC update; target and taken are combinational from the inputs.
- Reset while in TRAP returns to RUN at RESET_PC with no acknowledge required.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- With the macro: two 32-bit outputs are added.
  - o_br_cnt increments on every RUN, !i_stall cycle with i_br_en.
  - o_br_taken_cnt increments on the same cycles when the branch is also taken and aligned.
  - Both counters saturate at 0xFFFF_FFFF and reset to 0.
- Without the macro: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package rv32_br_pkg:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - State encoding ST_RUN = 1'b0, ST_TRAP = 1'b1.
  - XLEN = 32.
- One combinational sub-module, br_cond: maps i_funct3, i_lt and i_zero to the condition-true output.

Test Plan:
- Reset, then 3 cycles with no control transfer -> o_pc = 0x0, 0x4, 0x8, 0xC.
- At pc = 0x100, BLTU (110) with i_lt = 1, i_imm = 0x20 -> o_br_unsigned = 1, o_taken = 1, next o_pc = 0x120.
- BGE (101) with i_lt = 1 -> o_taken = 0, next o_pc = pc + 4.
- JALR with i_rs1 = 0x2001, i_imm = 0x1 at pc = 0x40 -> target 0x2002 is misaligned, so o_trap = 1 and o_mepc = 0x40 next cycle.
  - PC stays 0x40 for 5 cycles while stall toggles.
  - i_trap_ack -> o_pc = 0x10.
- i_stall = 1 with a taken BEQ -> PC holds; deasserting the stall with inputs unchanged -> branch taken.
- Reset asserted while in TRAP -> o_trap = 0 and o_pc = RESET_PC immediately, without waiting for a clock.
- With BRANCH_STATS_EN: 4 branches, 3 taken -> o_br_cnt = 4, o_br_taken_cnt = 3.
